// File: rtl/skid_reg_stage.sv
// skid_reg_stage: two-entry elastic valid/ready register with a compile-time combinational bypass.
module skid_reg_stage #(
  parameter int WIDTH  = 18,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       level
);
  if (BYPASS) begin : g_byp
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign level     = 2'd0;
  end else begin : g_reg
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t           state;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_acc, out_acc;
    // in_ready decodes only state (and reset), never out_ready, so no comb path crosses the stage
    assign in_ready  = (state != FULL) & rst_n;
    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign level     = state;
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state  <= EMPTY;
        main_q <= '0;
        skid_q <= '0;
      end else if (flush) state <= EMPTY;
      else case (state)
        EMPTY: if (in_acc) begin
          main_q <= in_data;
          state  <= ONE;
        end
        ONE: if (in_acc && out_acc) main_q <= in_data;
        else if (in_acc) begin
          skid_q <= in_data;
          state  <= FULL;
        end else if (out_acc) state <= EMPTY;
        FULL: if (out_acc) begin
          main_q <= skid_q;
          state  <= ONE;
        end
        default: state <= EMPTY;
      endcase
  end
endmodule

// File: doc/skid_reg_stage.md
# skid_reg_stage

Two-entry elastic pipeline register with a valid/ready handshake on both sides and a compile-time bypass. It is the flow-controlled counterpart of the team's enable-gated pipeline registers. Upstream logic produces operands. Downstream logic, such as the DSP48A1 slice model, consumes them and can stall, and no data may be lost when it does. It sits between operand producers and the slice input registers. It absorbs one cycle of backpressure while keeping full throughput.

## Interface
- WIDTH, 18: data width in bits.
- BYPASS, 0: when 1, the stage is purely combinational and holds no storage.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- flush  input  1  synchronous clear of the stored contents.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data is valid.
- in_ready  output  1  stage can accept data this cycle.
- out_data  output  WIDTH  downstream data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts data this cycle.
- level  output  2  number of stored entries (0, 1 or 2).

## Operation
- in_acc = in_valid & in_ready. out_acc = out_valid & out_ready.
- **BYPASS=1:**
  - out_data = in_data, out_valid = in_valid, in_ready = out_ready.
  - level = 0.
  - flush and clk have no effect.
  - Rest of this section applies to BYPASS=0.
- **Storage:**
  - main register: drives out_data.
  - skid register: holds one overflow entry.
- **State machine:** states EMPTY, ONE, FULL.
  - in_ready = (state != FULL) & rst_n.
  - out_valid = (state != EMPTY).
  - level = 0 / 1 / 2 for EMPTY / ONE / FULL.
- **EMPTY:**
  - in_acc: main <= in_data, go to ONE.
  - Otherwise stay in EMPTY.
- **ONE:**
  - in_acc & out_acc: main <= in_data, stay in ONE.
  - in_acc only: skid <= in_data, go to FULL.
  - out_acc only: go to EMPTY.
  - Neither: hold.
- **FULL:**
  - out_acc: main <= skid, go to ONE.
  - Otherwise hold. in_valid is ignored because in_ready = 0.
- **Ordering:** data leaves in exactly the order it was accepted. No entry is duplicated or dropped unless flush is used.
- **flush:**
  - Takes priority over every transition: next state is EMPTY.
  - Any in_acc or out_acc in the same cycle is discarded. Downstream must not count a handshake made in a flush cycle.
  - main and skid keep their contents; only the state is cleared.
- **Stall stability:** while out_valid = 1 and out_ready = 0, out_data and out_valid must not change.
- **Reset:**
  - rst_n low forces state EMPTY immediately, regardless of clk.
  - main and skid clear to 0.
  - Outputs during and directly after reset: out_valid = 0, out_data = 0, level = 0.
  - in_ready = 0 while rst_n is low. It becomes 1 combinationally on deassertion.
  - Reset in the middle of a transfer discards all stored entries.

## Timing
- **Latency:**
  - Data accepted at edge N appears on out_data after edge N, so it is available to downstream at cycle N+1.
  - Latency is exactly 1 cycle when the stage is not stalled.
- **Throughput:** one transfer per cycle sustained while out_ready = 1.
- **Registered outputs:**
  - out_valid, out_data and level are register outputs.
  - in_ready is decoded from state only. There is no combinational path from out_ready to in_ready.
- **Backpressure:**
  - When out_ready drops, the stage accepts at most one more entry, into skid.
  - in_ready falls on the edge after that acceptance.
- **Recovery:** from FULL, one out_acc returns the stage to ONE. in_ready is 1 in the next cycle.

## Test plan
- **Reset:**
  - Stimulus: assert rst_n = 0 asynchronously between clock edges while the stage is FULL.
  - Required response: level = 0, out_valid = 0, out_data = 0 and in_ready = 0 immediately. in_ready = 1 after release.
- **Streaming:**
  - Stimulus: send 0x00001..0x00010 with in_valid = 1 and out_ready = 1 every cycle.
  - Required response: out_data matches each input 1 cycle later, no bubbles, level stays at 1.
- **Skid:**
  - Stimulus: stream A, B, C with out_ready = 0 from the cycle A is presented.
  - Required response: A and B are accepted, level = 2, in_ready = 0, C is held upstream.
  - Then raise out_ready: A, B, C leave in order on consecutive cycles.
- **Flush:**
  - Stimulus: fill the stage to FULL, then assert flush for 1 cycle with in_valid = 1 and out_ready = 1.
  - Required response: next cycle level = 0, out_valid = 0, and the next accepted word is the first one out.
- **Random:**
  - Stimulus: 10k cycles of random in_valid, out_ready and in_data.
  - Required response: a scoreboard reports zero loss, zero duplication and zero reordering, and out_data is stable across every stalled cycle.
- **BYPASS=1:**
  - Stimulus: toggle in_valid, in_data and out_ready.
  - Required response: out_valid, out_data and in_ready follow combinationally with 0 cycles of latency, and level = 0 throughout.
